// File: rtl/la_readout_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : la_readout_streamer
//  Description : Readout side of the logic-analyzer capture buffer. When the
//                analyzer's capture-complete level rises, every entry of the
//                buffer is copied into a local snapshot. The snapshot is then
//                streamed one word per valid/ready handshake, followed by a
//                final word holding the XOR of all streamed entries.
//                Captures that complete while a frame is still in flight are
//                dropped and counted in a saturating overrun counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           : single clock, rising edge
//    rst           : synchronous active-high reset
//    capture_done  : analyzer capture-complete level (0->1 = new capture)
//    entries_in    : capture buffer, LA_NUM_ENTRY+1 words of LA_ENTRY_LENGTH
//    out_data      : stream word
//    out_valid     : out_data valid
//    out_ready     : downstream accepts the word when valid && ready
//    out_first     : marks the entry-0 word
//    out_last      : marks the checksum word (end of frame)
//    busy          : a frame is being streamed
//    overrun_cnt   : number of captures dropped while busy (saturating)
// ============================================================================
module la_readout_streamer #(
    parameter int LA_ENTRY_LENGTH = 16,
    parameter int LA_NUM_ENTRY    = 15,
    parameter int OVR_CNT_W       = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         capture_done,
    input  logic [LA_NUM_ENTRY:0][LA_ENTRY_LENGTH-1:0]   entries_in,
    output logic [LA_ENTRY_LENGTH-1:0]                   out_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         out_first,
    output logic                                         out_last,
    output logic                                         busy,
    output logic [OVR_CNT_W-1:0]                         overrun_cnt
);

    localparam int                   IDX_W      = (LA_NUM_ENTRY > 0) ? $clog2(LA_NUM_ENTRY + 1) : 1;
    localparam logic [IDX_W-1:0]     C_LAST_IDX = IDX_W'(LA_NUM_ENTRY);
    localparam logic [OVR_CNT_W-1:0] C_OVR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_CSUM   = 2'd2
    } state_t;

    state_t                                     r_state;
    state_t                                     w_state_nxt;

    logic                                       r_capture_done_q;
    logic [LA_NUM_ENTRY:0][LA_ENTRY_LENGTH-1:0] r_snap;
    logic [IDX_W-1:0]                           r_index;
    logic [LA_ENTRY_LENGTH-1:0]                 r_csum;
    logic [OVR_CNT_W-1:0]                       r_overrun_cnt;

    logic                                       w_start;
    logic                                       w_accept_start;
    logic                                       w_stream_hs;

    // The edge-detect register resets to 1 so that a capture_done level that
    // is already high when reset releases is not mistaken for a new capture.
    assign w_start        = capture_done && !r_capture_done_q;
    assign w_accept_start = w_start && (r_state == S_IDLE);
    assign w_stream_hs    = (r_state == S_STREAM) && out_ready;

    assign overrun_cnt    = r_overrun_cnt;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and stream outputs. Outputs decode directly from registered
    // state, so they stay stable for as long as the state does, which is
    // exactly until the handshake that moves the frame forward.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        out_first   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        busy        = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_STREAM;
                end
            end

            S_STREAM: begin
                out_valid = 1'b1;
                out_data  = r_snap[r_index];
                out_first = (r_index == '0);
                if (out_ready) begin
                    w_state_nxt = (r_index == C_LAST_IDX) ? S_CSUM : S_STREAM;
                end
            end

            S_CSUM: begin
                out_valid = 1'b1;
                out_data  = r_csum;
                out_last  = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: edge detect, snapshot, index, running checksum
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_capture_done_q <= 1'b1;
            r_index          <= '0;
            r_csum           <= '0;
        end else begin
            r_capture_done_q <= capture_done;

            if (w_accept_start) begin
                r_index <= '0;
                r_csum  <= '0;
            end else if (w_stream_hs) begin
                // The checksum accumulates exactly the words the consumer took,
                // so by the time the CSUM state is reached it covers all entries.
                r_csum <= r_csum ^ r_snap[r_index];
                if (r_index != C_LAST_IDX) begin
                    r_index <= r_index + 1'b1;
                end
            end
        end
    end

    // The snapshot needs no reset: it is only read after a start has loaded it.
    always_ff @(posedge clk) begin
        if (w_accept_start && !rst) begin
            r_snap <= entries_in;
        end
    end

    // ------------------------------------------------------------------------
    // Overrun counter: a start seen in any non-idle state (including the cycle
    // of the final checksum handshake) is dropped and counted.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun_cnt <= '0;
        end else if (w_start && (r_state != S_IDLE) && (r_overrun_cnt != C_OVR_MAX)) begin
            r_overrun_cnt <= r_overrun_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_la_readout_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_la_readout_streamer
//  Description : Directed self-checking bench for la_readout_streamer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_la_readout_streamer;

    localparam int W = 16;
    localparam int N = 15;

    logic                 clk;
    logic                 rst;
    logic                 capture_done;
    logic [N:0][W-1:0]    entries_in;
    logic [W-1:0]         out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_first;
    logic                 out_last;
    logic                 busy;
    logic [7:0]           overrun_cnt;

    int total;
    int bad;

    logic [W-1:0] exp_w     [0:N+1];
    logic [W-1:0] got_data  [0:63];
    logic         got_first [0:63];
    logic         got_last  [0:63];
    int           got_n;
    int           got_cycles;

    la_readout_streamer #(
        .LA_ENTRY_LENGTH (W),
        .LA_NUM_ENTRY    (N),
        .OVR_CNT_W       (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .capture_done (capture_done),
        .entries_in   (entries_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_first    (out_first),
        .out_last     (out_last),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: entry i = 0x1000+i ; mode 1: all 0xA5A5 except entry 3 = 0x0001
    task automatic load_entries(input int mode);
        logic [W-1:0] x;
        x = '0;
        for (int i = 0; i <= N; i++) begin
            if (mode == 0) entries_in[i] = 16'h1000 + 16'(i);
            else           entries_in[i] = (i == 3) ? 16'h0001 : 16'hA5A5;
            exp_w[i] = entries_in[i];
            x = x ^ entries_in[i];
        end
        exp_w[N+1] = x;
    endtask

    // Rising edge on capture_done for one cycle, then back low.
    task automatic pulse_start();
        capture_done = 1'b1;
        step();
        capture_done = 1'b0;
    endtask

    // Consume one frame. rmode 0: ready held high; 1: ready random.
    // pulse_last raises capture_done on the cycle of the checksum handshake.
    task automatic collect(input int rmode, input bit pulse_last);
        bit           done;
        bit           hold_v;
        logic [W-1:0] hold_d;
        int           cyc;
        done   = 1'b0;
        hold_v = 1'b0;
        hold_d = '0;
        got_n  = 0;
        cyc    = 0;
        while (cyc < 400 && !done) begin
            out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (hold_v) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(hold_d));
            end
            if (out_valid && out_ready) begin
                if (got_n < 64) begin
                    got_data[got_n]  = out_data;
                    got_first[got_n] = out_first;
                    got_last[got_n]  = out_last;
                end
                got_n++;
                hold_v = 1'b0;
                if (out_last) begin
                    done = 1'b1;
                    if (pulse_last) capture_done = 1'b1;
                end
            end else if (out_valid) begin
                hold_v = 1'b1;
                hold_d = out_data;
            end else begin
                hold_v = 1'b0;
            end
            step();
            cyc++;
        end
        got_cycles = cyc;
        if (!done) check("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_nwords"}, 32'(got_n), 32'(N + 2));
        for (int i = 0; i < N + 2 && i < got_n; i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(exp_w[i]));
            check($sformatf("%s_first%0d", tag, i), 32'(got_first[i]), 32'(i == 0));
            check($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == N + 1));
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        capture_done = 1'b0;
        out_ready    = 1'b0;
        entries_in   = '0;
        void'($urandom(32'd1234));
        step();
        step();

        // Reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_first", 32'(out_first), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_ovr", 32'(overrun_cnt), 32'd0);
        rst = 1'b0;
        step();

        // T1: ramp entries, zero-bubble stream
        load_entries(0);
        out_ready = 1'b1;
        pulse_start();
        check("t1_latency_valid", 32'(out_valid), 32'd1);
        check("t1_latency_data", 32'(out_data), 32'h1000);
        check("t1_busy", 32'(busy), 32'd1);
        collect(0, 1'b0);
        check_frame("t1");
        check("t1_csum", 32'(got_data[N+1]), 32'h0000);
        check("t1_cycles", 32'(got_cycles), 32'(N + 2));
        check("t1_idle", 32'(busy), 32'd0);

        // T2: checksum with one odd entry
        load_entries(1);
        pulse_start();
        collect(0, 1'b0);
        check_frame("t2");
        check("t2_csum", 32'(got_data[N+1]), 32'hA5A4);

        // T3: random backpressure
        load_entries(0);
        out_ready = 1'b0;
        pulse_start();
        collect(1, 1'b0);
        check_frame("t3");

        // T4: overruns during STREAM and on the final checksum handshake
        out_ready = 1'b0;
        pulse_start();
        step();
        capture_done = 1'b1;
        step();
        capture_done = 1'b0;
        check("t4_ovr1", 32'(overrun_cnt), 32'd1);
        check("t4_hold_data", 32'(out_data), 32'h1000);
        collect(0, 1'b1);
        capture_done = 1'b0;
        check_frame("t4");
        check("t4_ovr2", 32'(overrun_cnt), 32'd2);
        check("t4_idle", 32'(busy), 32'd0);
        step();
        check("t4_no_restart", 32'(busy), 32'd0);

        // T4b: saturation
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 253; i++) begin
            step();
            capture_done = 1'b1;
            step();
            capture_done = 1'b0;
        end
        check("t4_ovr255", 32'(overrun_cnt), 32'hFF);
        for (int i = 0; i < 47; i++) begin
            step();
            capture_done = 1'b1;
            step();
            capture_done = 1'b0;
        end
        check("t4_ovr_sat", 32'(overrun_cnt), 32'hFF);
        step();
        collect(0, 1'b0);
        check_frame("t4b");

        // T5: reset mid-frame
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 7; i++) step();
        check("t5_word7", 32'(out_data), 32'h1007);
        rst = 1'b1;
        step();
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_data", 32'(out_data), 32'd0);
        check("t5_ovr", 32'(overrun_cnt), 32'd0);
        rst = 1'b0;
        step();
        load_entries(1);
        pulse_start();
        collect(0, 1'b0);
        check_frame("t5");

        // T6: capture_done high through reset release, snapshot isolation
        rst          = 1'b1;
        capture_done = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t6_no_frame", 32'(busy), 32'd0);
        check("t6_no_valid", 32'(out_valid), 32'd0);
        capture_done = 1'b0;
        step();
        load_entries(0);
        pulse_start();
        check("t6_busy", 32'(busy), 32'd1);
        for (int i = 0; i <= N; i++) entries_in[i] = 16'hFFFF;
        collect(0, 1'b0);
        check_frame("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
